inst_queue: RTL and testbench

Parametrised instruction buffer between the instruction fetcher and the decoder. It replaces the single-slot fetch-to-decode handoff with a DEPTH-entry in-order FIFO. Each entry holds {instruction, pc, predicted next pc} and is pre-decoded on the way out: compressed/full length and sequential next pc. The queue supports almost-full back-pressure, a same-cycle push/pop when full, a single-cycle flush on redirect, and an optional empty-queue bypass.

---
 rtl/inst_queue.sv | 119 +++++++++++
 tb/tb_inst_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// In-order instruction buffer between fetch and decode with flush, almost-full
// back-pressure and head pre-decode. Define IQ_BYPASS_EN for the empty-queue bypass.
module inst_queue #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AFULL_SLACK = 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     in_valid,
   input  logic [31:0]              in_ins,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_pred_pc,
   output logic                     in_stall,
   output logic                     out_valid,
   output logic [31:0]              out_ins,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pred_pc,
   output logic                     out_is_c,
   output logic [31:0]              out_seq_pc,
   input  logic                     out_pop,
   input  logic                     flush_in,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pred_pc;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] head, head_nxt;
   logic [AW-1:0] tail, tail_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          stall_nxt;

   entry_t        in_entry;
   entry_t        out_entry;
   logic          empty;
   logic          full;
   logic          byp;
   logic          pop;
   logic          pop_mem;
   logic          push;
   logic          push_mem;

   // Stored pc always has bit 0 cleared so out_pc never needs masking.
   assign in_entry = '{ins: in_ins, pc: in_pc & 32'hFFFF_FFFE, pred_pc: in_pred_pc};
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));

`ifdef IQ_BYPASS_EN
   // Empty queue forwards the fetcher's entry straight to the decoder.
   assign byp       = empty && in_valid && rdy_in && !flush_in;
   assign out_entry = byp ? in_entry : mem[head];
`else
   assign byp       = 1'b0;
   assign out_entry = mem[head];
`endif

   assign out_valid = !empty || byp;
   assign pop       = out_pop && out_valid;
   assign push      = in_valid && (!full || pop);
   assign pop_mem   = pop && !empty;
   // A bypassed entry that is consumed in the same cycle never lands in storage.
   assign push_mem  = push && !(byp && pop);

   assign out_ins     = out_entry.ins;
   assign out_pc      = out_entry.pc;
   assign out_pred_pc = out_entry.pred_pc;
   assign out_is_c    = (out_entry.ins[1:0] != 2'b11);
   assign out_seq_pc  = out_entry.pc + (out_is_c ? 32'd2 : 32'd4);
   assign count_out   = count;

   // Next pointer/count state; flush dominates, rdy_in low freezes everything.
   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      if (rdy_in) begin
         if (flush_in) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
         end else begin
            if (push_mem) tail_nxt = tail + AW'(1);
            if (pop_mem)  head_nxt = head + AW'(1);
            count_nxt = count + CW'(push_mem) - CW'(pop_mem);
         end
      end
      stall_nxt = ((CW'(DEPTH) - count_nxt) <= CW'(AFULL_SLACK));
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         in_stall <= 1'b0;
      end else begin
         head     <= head_nxt;
         tail     <= tail_nxt;
         count    <= count_nxt;
         in_stall <= stall_nxt;
      end
   end

   // Entry storage is not reset; stale contents are masked by out_valid.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !flush_in && push_mem) begin
         mem[tail] <= in_entry;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model compared every
// cycle, plus directed literal checks from the block's test plan.
module tb_inst_queue;

   localparam int unsigned DEPTH       = 8;
   localparam int unsigned AFULL_SLACK = 1;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        in_valid;
   logic [31:0] in_ins;
   logic [31:0] in_pc;
   logic [31:0] in_pred_pc;
   logic        in_stall;
   logic        out_valid;
   logic [31:0] out_ins;
   logic [31:0] out_pc;
   logic [31:0] out_pred_pc;
   logic        out_is_c;
   logic [31:0] out_seq_pc;
   logic        out_pop;
   logic        flush_in;
   logic [$clog2(DEPTH):0] count_out;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   ent_t q[$];

   inst_queue #(.DEPTH(DEPTH), .AFULL_SLACK(AFULL_SLACK)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_pred_pc(in_pred_pc),
      .in_stall(in_stall), .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
      .out_pred_pc(out_pred_pc), .out_is_c(out_is_c), .out_seq_pc(out_seq_pc),
      .out_pop(out_pop), .flush_in(flush_in), .count_out(count_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_byp(input int sz);
`ifdef IQ_BYPASS_EN
      return (sz == 0) && in_valid && rdy_in && !flush_in;
`else
      return 1'b0;
`endif
   endfunction

   function automatic ent_t in_ent();
      ent_t e;
      e.ins  = in_ins;
      e.pc   = in_pc & 32'hFFFF_FFFE;
      e.pred = in_pred_pc;
      return e;
   endfunction

   // Reference model: plain FIFO of entries updated at each accepted edge.
   always @(posedge clk_in) begin
      int  sz;
      bit  b, ev, pop, push;
      if (rst_in && rdy_in) begin
         if (flush_in) begin
            q.delete();
         end else begin
            sz   = q.size();
            b    = model_byp(sz);
            ev   = (sz > 0) || b;
            pop  = out_pop && ev;
            push = in_valid && ((sz < DEPTH) || pop);
            if (b) begin
               if (!pop) q.push_back(in_ent());
            end else begin
               if (pop)  void'(q.pop_front());
               if (push) q.push_back(in_ent());
            end
         end
      end
   end

   always @(negedge rst_in) q.delete();

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk_in) begin
      int   sz;
      bit   b, ev, isc;
      ent_t h;
      sz = q.size();
      b  = model_byp(sz);
      ev = (sz > 0) || b;
      check("count_out", 32'(count_out), 32'(sz));
      check("in_stall", 32'(in_stall), 32'((DEPTH - sz) <= AFULL_SLACK));
      check("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
         if (sz > 0) h = q[0];
         else        h = in_ent();
         isc = (h.ins[1:0] != 2'b11);
         check("out_ins", out_ins, h.ins);
         check("out_pc", out_pc, h.pc);
         check("out_pred_pc", out_pred_pc, h.pred);
         check("out_is_c", 32'(out_is_c), 32'(isc));
         check("out_seq_pc", out_seq_pc, h.pc + (isc ? 32'd2 : 32'd4));
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_push(input logic [31:0] ins, input logic [31:0] pc);
      in_valid   = 1'b1;
      in_ins     = ins;
      in_pc      = pc;
      in_pred_pc = pc + 32'd4;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      out_pop  = 1'b0;
      flush_in = 1'b0;
      rdy_in   = 1'b1;
   endtask

   initial begin
      rst_in     = 1'b0;
      rdy_in     = 1'b1;
      in_valid   = 1'b0;
      in_ins     = '0;
      in_pc      = '0;
      in_pred_pc = '0;
      out_pop    = 1'b0;
      flush_in   = 1'b0;
      #12;
      check("rst count", 32'(count_out), 32'd0);
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst stall", 32'(in_stall), 32'd0);
      step();
      rst_in = 1'b1;

      // Three pushes, then ordered pops with pre-decode.
      drive_push(32'h0000_0013, 32'h0); step();
      drive_push(32'h0000_4501, 32'h4); step();
      drive_push(32'h00a0_0093, 32'h6); step();
      in_valid = 1'b0; settle();
      check("three count", 32'(count_out), 32'd3);
      out_pop = 1'b1; settle();
      check("pop0 is_c", 32'(out_is_c), 32'd0);
      check("pop0 seq", out_seq_pc, 32'h4);
      step(); settle();
      check("pop1 is_c", 32'(out_is_c), 32'd1);
      check("pop1 seq", out_seq_pc, 32'h6);
      step(); settle();
      check("pop2 is_c", 32'(out_is_c), 32'd0);
      check("pop2 seq", out_seq_pc, 32'ha);
      step();
      idle(); settle();
      check("drained valid", 32'(out_valid), 32'd0);

      // Fill to almost-full, full, dropped push, push+pop at full across wrap.
      for (int i = 0; i < 6; i++) begin
         drive_push($urandom(), 32'h1000 + 32'(i * 4)); step();
      end
      in_valid = 1'b0; settle();
      check("six stall", 32'(in_stall), 32'd0);
      drive_push($urandom(), 32'h1018); step();
      in_valid = 1'b0; settle();
      check("seven stall", 32'(in_stall), 32'd1);
      check("seven count", 32'(count_out), 32'd7);
      drive_push($urandom(), 32'h101c); step();
      in_valid = 1'b0; settle();
      check("full count", 32'(count_out), 32'd8);
      drive_push($urandom(), 32'h1020); step();
      in_valid = 1'b0; settle();
      check("drop count", 32'(count_out), 32'd8);
      check("drop head pc", out_pc, 32'h1000);
      out_pop = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive_push($urandom(), 32'h2000 + 32'(i * 2)); step();
      end
      in_valid = 1'b0; settle();
      check("full pp count", 32'(count_out), 32'd8);
      check("wrap head pc", out_pc, 32'h2008);
      step(); step(); step();
      out_pop = 1'b0; settle();
      check("five count", 32'(count_out), 32'd5);

      // Flush dominates push and pop.
      flush_in = 1'b1; out_pop = 1'b1;
      drive_push($urandom(), 32'h3000); step();
      idle(); settle();
      check("flush count", 32'(count_out), 32'd0);
      check("flush valid", 32'(out_valid), 32'd0);

      // rdy_in low freezes state.
      for (int i = 0; i < 4; i++) begin
         drive_push($urandom(), 32'h200 + 32'(i * 4)); step();
      end
      rdy_in = 1'b0; out_pop = 1'b1;
      drive_push($urandom(), 32'h4000);
      step(); step(); step();
      settle();
      check("rdy count", 32'(count_out), 32'd4);
      check("rdy head pc", out_pc, 32'h200);
      idle(); settle();

      // Asynchronous reset mid-cycle.
      rst_in = 1'b0; settle();
      check("arst count", 32'(count_out), 32'd0);
      check("arst valid", 32'(out_valid), 32'd0);
      #2;
      rst_in = 1'b1;
      step();

`ifdef IQ_BYPASS_EN
      drive_push(32'h0000_0013, 32'h100); out_pop = 1'b1; settle();
      check("byp valid", 32'(out_valid), 32'd1);
      check("byp pc", out_pc, 32'h100);
      step();
      idle(); settle();
      check("byp count", 32'(count_out), 32'd0);
`endif

      // Randomized traffic with shifting push/pop bias.
      for (int seg = 0; seg < 12; seg++) begin
         int pv, pp;
         pv = 30 + 10 * int'($urandom_range(0, 6));
         pp = 30 + 10 * int'($urandom_range(0, 6));
         for (int i = 0; i < 200; i++) begin
            in_valid   = ($urandom_range(0, 99) < pv);
            in_ins     = $urandom();
            in_pc      = $urandom();
            in_pred_pc = $urandom();
            out_pop    = ($urandom_range(0, 99) < pp);
            flush_in   = ($urandom_range(0, 99) < 2);
            rdy_in     = ($urandom_range(0, 99) < 90);
            step();
         end
      end
      idle();
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
